// File: rtl/counter_32bit.sv
// Free-running binary up-counter with clock enable and a one-cycle wrap flag.
// Counts 0..TERMINAL and wraps to 0, pulsing overflow in the cycle count reads 0.
module counter_32bit #(
    parameter int unsigned            WIDTH    = 32,
    parameter logic [WIDTH-1:0]       TERMINAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= ZERO;
            overflow <= 1'b0;
        end else if (enable) begin
            if (count == TERMINAL) begin
                count    <= ZERO;
                overflow <= 1'b1;
            end else if (count > TERMINAL) begin
                // Out-of-range value (e.g. after an override): recover silently.
                count    <= ZERO;
                overflow <= 1'b0;
            end else begin
                count    <= count + ONE;
                overflow <= 1'b0;
            end
        end else begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_counter_32bit.sv
// Directed bench for counter_32bit: default 32-bit instance plus an 8-bit
// instance wrapping at 9, checked against a reference model through a queue.
module tb_counter_32bit;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [31:0] count;
    logic        overflow;

    logic        rst8_n;
    logic        enable8;
    logic [7:0]  count8;
    logic        overflow8;

    typedef struct {
        logic [63:0] cnt;
        logic        ov;
    } exp_t;

    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_cnt;
    logic        m_ov;
    logic [7:0]  m8_cnt;
    logic        m8_ov;
    int          pulses;

    counter_32bit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .count    (count),
        .overflow (overflow)
    );

    counter_32bit #(.WIDTH(8), .TERMINAL(8'd9)) dut8 (
        .clk      (clk),
        .rst_n    (rst8_n),
        .enable   (enable8),
        .count    (count8),
        .overflow (overflow8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_pop(input string tag, input logic [63:0] cnt_obs, input logic ov_obs);
        exp_t e;
        if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed count=%h ov=%b", tag, cnt_obs, ov_obs);
            return;
        end
        e = q.pop_front();
        n_checks++;
        assert (cnt_obs === e.cnt && ov_obs === e.ov)
        else begin
            n_fail++;
            $error("FAIL %s: observed count=%h ov=%b, expected count=%h ov=%b",
                   tag, cnt_obs, ov_obs, e.cnt, e.ov);
        end
    endtask

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference model for the 32-bit instance, advanced once per rising edge.
    task automatic step32(input string tag);
        exp_t e;
        if (!rst_n) begin
            m_cnt = '0;
            m_ov  = 1'b0;
        end else if (enable) begin
            m_ov  = (m_cnt == 32'hFFFF_FFFF);
            m_cnt = m_cnt + 32'd1;
        end else begin
            m_ov = 1'b0;
        end
        e.cnt = {32'd0, m_cnt};
        e.ov  = m_ov;
        q.push_back(e);
        @(posedge clk);
        #1;
        check_pop(tag, {32'd0, count}, overflow);
        if (overflow) pulses++;
    endtask

    task automatic step8(input string tag);
        exp_t e;
        if (!rst8_n) begin
            m8_cnt = '0;
            m8_ov  = 1'b0;
        end else if (enable8) begin
            if (m8_cnt == 8'd9) begin
                m8_cnt = 8'd0;
                m8_ov  = 1'b1;
            end else if (m8_cnt > 8'd9) begin
                m8_cnt = 8'd0;
                m8_ov  = 1'b0;
            end else begin
                m8_cnt = m8_cnt + 8'd1;
                m8_ov  = 1'b0;
            end
        end else begin
            m8_ov = 1'b0;
        end
        e.cnt = {56'd0, m8_cnt};
        e.ov  = m8_ov;
        q.push_back(e);
        @(posedge clk);
        #1;
        check_pop(tag, {56'd0, count8}, overflow8);
        if (overflow8) pulses++;
    endtask

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b0;
        rst8_n  = 1'b0;
        enable8 = 1'b0;
        m_cnt   = 32'hDEAD_BEEF;
        m_ov    = 1'b1;
        m8_cnt  = 8'hAA;
        m8_ov   = 1'b1;
        pulses  = 0;

        // Reset held for two cycles, then released with enable low.
        step32("reset_0");
        step32("reset_1");
        check_val("reset_count", {32'd0, count}, 64'd0);
        rst_n = 1'b1;
        step32("release_idle");

        enable = 1'b1;
        for (int i = 0; i < 20; i++) step32("count_up");
        check_val("count_20", {32'd0, count}, 64'h14);

        enable = 1'b0;
        for (int i = 0; i < 5; i++) step32("hold");
        check_val("hold_value", {32'd0, count}, 64'h14);

        enable = 1'b1;
        for (int i = 0; i < 10; i++) step32("resume");
        check_val("resume_value", {32'd0, count}, 64'h1E);

        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_count", {32'd0, count}, 64'd0);
        check_val("async_rst_ov", {63'd0, overflow}, 64'd0);
        m_cnt = '0;
        m_ov  = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step32("post_rst");
        check_val("post_rst_value", {32'd0, count}, 64'h14);

        // Wrap via an override of the state register.
        enable = 1'b0;
        force dut.count = 32'hFFFF_FFF0;
        m_cnt = 32'hFFFF_FFF0;
        step32("forced_hold");
        release dut.count;
        #1;
        check_val("after_release", {32'd0, count}, 64'hFFFF_FFF0);
        enable = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) step32("pre_wrap");
        check_val("at_terminal", {32'd0, count}, 64'hFFFF_FFFF);
        step32("wrap_edge");
        check_val("wrap_ov", {63'd0, overflow}, 64'd1);
        step32("post_wrap");
        check_val("post_wrap_count", {32'd0, count}, 64'd1);
        check_val("one_pulse", 64'(pulses), 64'd1);
        enable = 1'b0;

        // Small instance wrapping at 9.
        step8("r8_reset");
        rst8_n  = 1'b1;
        enable8 = 1'b1;
        pulses  = 0;
        for (int i = 0; i < 25; i++) step8("r8_count");
        check_val("r8_after25", {56'd0, count8}, 64'd5);
        check_val("r8_pulses", 64'(pulses), 64'd2);
        for (int i = 0; i < 5; i++) step8("r8_to_wrap");
        check_val("r8_ov_high", {63'd0, overflow8}, 64'd1);
        #2;
        rst8_n = 1'b0;
        #1;
        check_val("r8_rst_ov", {63'd0, overflow8}, 64'd0);
        check_val("r8_rst_count", {56'd0, count8}, 64'd0);
        m8_cnt = '0;
        m8_ov  = 1'b0;
        step8("r8_held");

        check_val("queue_drained", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_32bit.md
# counter_32bit

Parameterized free-running binary up-counter with clock enable and a single-cycle wrap (overflow) flag. It serves as a general-purpose event/cycle counter in the design. It increments by one on every enabled rising clock edge. It wraps from its terminal value back to zero, flagging the wrap for exactly one cycle.

## Interface

Parameters:
- WIDTH, default 32: counter width in bits; legal range 2..64.
- TERMINAL, default all-ones of WIDTH ({WIDTH{1'b1}}): last value reached before wrapping to 0; must be nonzero and fit in WIDTH bits.

Ports (one clock; reset is asynchronous and active-low):
- clk, input, 1: rising-edge clock; all state updates occur here except reset.
- rst_n, input, 1: asynchronous active-low reset; clears all state immediately on assertion; deassertion takes effect at the next clk rising edge.
- enable, input, 1: count enable, sampled on clk rising edge.
- count, output, WIDTH: current count value; driven directly by the state register (output reg named count, no intermediate copy).
- overflow, output, 1: registered wrap flag; high for the one cycle after a TERMINAL -> 0 transition.

## Operation

- State: the count register plus the overflow register only; no FSM.
- Reset (rst_n = 0, any time, independent of clk): count = 0, overflow = 0; held while rst_n low.
- On each clk rising edge with rst_n = 1:
  - enable = 1, count != TERMINAL: count <= count + 1, overflow <= 0.
  - enable = 1, count == TERMINAL: count <= 0, overflow <= 1.
  - enable = 0: count holds, overflow <= 0.
- Arithmetic is modulo the TERMINAL+1 range. count never exceeds TERMINAL through normal counting.
- If count holds a value above TERMINAL (e.g. externally overridden), the next enabled edge loads 0 with overflow = 0. The wrap comparison is equality only.
- Because count is the state register itself, a hierarchical force/release of count becomes the live state after release. Counting resumes from that value on the next enabled edge.
- overflow never asserts on reset release or while enable = 0. Consecutive wraps are only possible when TERMINAL = 1 (alternating pattern).

## Timing

- Latency: enable sampled high at edge N -> count reflects +1 after edge N (same edge, no pipeline).
- overflow is asserted in the same cycle in which count reads 0 after a wrap. It drops at the next rising edge regardless of enable.
- enable deasserted at edge N: count frozen from edge N onward; overflow low after edge N.
- Reset mid-operation: count and overflow go to 0 asynchronously within the assertion delta, not waiting for clk. A pending wrap is discarded.
- First increment after rst_n release occurs on the first rising edge at which rst_n = 1 and enable = 1.
- Outputs are glitch-free registered values; no combinational path from enable to any output.

## Test plan

- Reset: rst_n = 0 for 2 cycles with enable = 0 -> count = 0x00000000, overflow = 0. Release rst_n, hold enable = 0 for 1 cycle -> count stays 0.
- Count: enable = 1 for 20 edges from 0 -> count steps 1,2,…,0x14 one per edge; overflow stays 0.
- Hold: enable = 0 for 5 edges at count = 0x14 -> count stays 0x14. Re-enable for 10 edges -> count = 0x1E.
- Async reset mid-count: drop rst_n between edges at count = 0x1E -> count = 0 and overflow = 0 immediately, before the next edge. Release with enable = 1 -> 20 edges reach 0x14.
- Wrap: force count = 0xFFFFFFF0 across an edge, release, enable = 1. After 15 edges count = 0xFFFFFFFF, overflow = 0. 16th edge: count = 0x00000000, overflow = 1. 17th edge: count = 0x00000001, overflow = 0. Exactly one overflow pulse is reported.
- Parameterization: WIDTH = 8, TERMINAL = 9, enable = 1 for 25 edges from reset -> sequence 0..9 repeating. overflow is high in exactly the cycles where count returns to 0 (after edges 10 and 20). Reset during an overflow-high cycle clears overflow at once.
